// File: rtl/if_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   fetch_state_e   : fetch FSM state encoding
//   npc_sel_e       : select code for the next-PC mux (if_next_pc)
//   NOP_INST        : bubble word presented to IF/ID
//   PC_STEP_DEFAULT : default byte increment for a sequential fetch
// ----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_SEQ      = 2'd1,
    NPC_BRANCH   = 2'd2,
    NPC_REDIRECT = 2'd3
  } npc_sel_e;

  localparam logic [31:0] NOP_INST        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

endpackage

// File: rtl/if_fetch_stage_next_pc.sv
// ----------------------------------------------------------------------------
// if_next_pc
// Combinational next-PC mux for the fetch stage.
// Ports:
//   sel_i           : npc_sel_e code (hold / +PC_STEP / branch / redirect)
//   pc_i            : current PC
//   branch_target_i : branch target from EX
//   redirect_pc_i   : branch target latched while a dropped fetch drains
//   next_pc_o       : selected next PC (32-bit, wraps modulo 2^32)
// ----------------------------------------------------------------------------
module if_next_pc
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i;
    case (npc_sel_e'(sel_i))
      NPC_HOLD:     next_pc_o = pc_i;
      NPC_SEQ:      next_pc_o = pc_i + PC_STEP;
      NPC_BRANCH:   next_pc_o = branch_target_i;
      NPC_REDIRECT: next_pc_o = redirect_pc_i;
      default:      next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, drives a
// req/ack instruction memory with variable latency and presents pc_if/inst_if,
// inserting NOP bubbles while memory is waiting or a stale fetch is dropped.
//
// Ports:
//   clk, rst_n               : clock (rising edge), async active-low reset
//   load_stop                : load-use stall, freezes PC and presented word
//   is_branch, branch_target : taken branch redirect (ignored under load_stop)
//   imem_req, imem_addr      : fetch request / address
//   imem_ack, imem_rdata     : fetch response (ack may be same cycle as req)
//   pc_if, inst_if           : PC and instruction presented to IF/ID
//   fetch_wait               : inst_if is a bubble due to memory wait / drop
//   perf_fetch_cnt,
//   perf_bubble_cnt          : only when IF_FETCH_PERF_EN is defined
//
// Optional feature macro: IF_FETCH_PERF_EN (performance counters).
// ----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_stop,
  input  logic        is_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] inst_if,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic        fetch_wait
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_buf_q, inst_buf_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  stale_pc_q, stale_pc_d;
  npc_sel_e     npc_sel;

  logic         ack_v;
  logic         br_v;
  logic         req_raw;
  logic         wait_raw;

  // A late ack while reset is asserted must not leak into inst_if.
  assign ack_v = imem_ack & rst_n;
  // load_stop has priority over is_branch, as in IF/ID.
  assign br_v  = is_branch & ~load_stop;

  always_comb begin
    state_d       = state_q;
    inst_buf_d    = inst_buf_q;
    redirect_pc_d = redirect_pc_q;
    stale_pc_d    = stale_pc_q;
    npc_sel       = NPC_HOLD;
    req_raw       = 1'b0;
    imem_addr     = pc_q;
    inst_if       = NOP_INST;
    wait_raw      = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_raw = 1'b1;
        if (ack_v) begin
          inst_if = imem_rdata;
          if (load_stop) begin
            inst_buf_d = imem_rdata;
            state_d    = S_HOLD;
          end else if (is_branch) begin
            npc_sel = NPC_BRANCH;
          end else begin
            npc_sel = NPC_SEQ;
          end
        end else begin
          wait_raw = 1'b1;
          // Request cannot be withdrawn: keep it alive at the old address
          // and discard its data when it finally arrives.
          if (br_v) begin
            redirect_pc_d = branch_target;
            stale_pc_d    = pc_q;
            state_d       = S_DROP;
          end
        end
      end

      S_HOLD: begin
        inst_if = inst_buf_q;
        if (!load_stop) begin
          state_d = S_FETCH;
          npc_sel = is_branch ? NPC_BRANCH : NPC_SEQ;
        end
      end

      S_DROP: begin
        req_raw   = 1'b1;
        imem_addr = stale_pc_q;
        wait_raw  = 1'b1;
        if (br_v) begin
          redirect_pc_d = branch_target;
        end
        if (ack_v) begin
          state_d = S_FETCH;
          // A branch arriving with the ack is the latest one and wins.
          npc_sel = br_v ? NPC_BRANCH : NPC_REDIRECT;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem_req   = req_raw & rst_n;
  assign fetch_wait = wait_raw & rst_n;
  assign pc_if      = pc_q;

  if_next_pc #(
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .sel_i           (npc_sel),
    .pc_i            (pc_q),
    .branch_target_i (branch_target),
    .redirect_pc_i   (redirect_pc_q),
    .next_pc_o       (pc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      inst_buf_q    <= NOP_INST;
      redirect_pc_q <= 32'h0;
      stale_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      redirect_pc_q <= redirect_pc_d;
      stale_pc_q    <= stale_pc_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if ((state_q == S_FETCH) && ack_v && !load_stop) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (fetch_wait) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC register and next-PC selection (sequential +4 / branch redirect).
- Drives a req/ack instruction-memory port with variable latency (0..N wait cycles).
- Presents pc_if/inst_if to IF/ID; inserts NOP (32'h0) bubbles while memory is waiting.
- Honours the same load_stop / is_branch controls that IF/ID receives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- PC_STEP, 4, byte increment for a sequential fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_stop  input  1  load-use stall from ID; freezes PC and the presented instruction.
- is_branch  input  1  taken branch/jump from EX; redirect to branch_target.
- branch_target  input  32  redirect PC, valid when is_branch=1.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  response valid; may be asserted in the same cycle as imem_req (zero-wait).
- imem_rdata  input  32  instruction word, valid with imem_ack.
- pc_if  output  32  PC of the presented instruction.
- inst_if  output  32  presented instruction; 32'h0 = bubble.
- fetch_wait  output  1  high when inst_if is a bubble caused by memory wait or drop.

Behaviour:
- Reset (async): pc=RESET_PC, state=S_FETCH, inst_buf=0, redirect_pc=0. Outputs: imem_req=0 (gated by rst_n), pc_if=RESET_PC, inst_if=0, fetch_wait=0.
- States: S_FETCH, S_HOLD, S_DROP.
- imem_req=1 in S_FETCH and S_DROP. imem_addr=pc in S_FETCH, stale_pc in S_DROP.
- S_FETCH, imem_ack=1:
  - inst_if=imem_rdata (combinational pass-through); pc_if=pc.
  - load_stop=1: inst_buf<=imem_rdata; go to S_HOLD; pc unchanged.
  - else is_branch=1: pc<=branch_target; stay in S_FETCH. The presented word is flushed by IF/ID.
  - else pc<=pc+PC_STEP; stay in S_FETCH.
- S_FETCH, imem_ack=0:
  - inst_if=0, fetch_wait=1, pc_if=pc.
  - is_branch=1 (and load_stop=0): redirect_pc<=branch_target; stale_pc<=pc; go to S_DROP. The request must not be withdrawn.
  - else stay in S_FETCH.
- S_HOLD:
  - imem_req=0; inst_if=inst_buf; pc_if=pc.
  - load_stop=1: stay.
  - else is_branch=1: pc<=branch_target; go to S_FETCH.
  - else pc<=pc+PC_STEP; go to S_FETCH.
- S_DROP:
  - inst_if=0, fetch_wait=1.
  - On imem_ack: discard the data; pc<=redirect_pc; go to S_FETCH.
  - A further is_branch while in S_DROP overwrites redirect_pc (last branch wins).
- Priority: load_stop over is_branch, matching IF/ID; is_branch is ignored in a cycle where load_stop=1.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000. No alignment check; branch_target[1:0] is passed through unchanged.
- Latency: zero-wait memory gives 1 instruction per cycle, PC sequence RESET_PC, +4, +8, ... Each memory wait cycle adds one bubble.
- Reset mid-request: state returns to S_FETCH and imem_req drops immediately. A late ack arriving during reset is ignored.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_fetch_cnt increments on each S_FETCH ack that is not stalled by load_stop.
  - perf_bubble_cnt increments on each cycle with fetch_wait=1.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - fetch state encoding (S_FETCH=2'd0, S_HOLD=2'd1, S_DROP=2'd2);
  - NOP_INST=32'h0;
  - PC_STEP default.
- One natural sub-module: if_next_pc, the combinational next-PC mux covering hold, +PC_STEP, branch_target and redirect_pc.

Test Plan:
- Zero-wait memory (ack tied high), RESET_PC=0, 4 cycles -> pc_if 0,4,8,12; inst_if equals the memory contents; fetch_wait=0 throughout.
- 2-cycle-latency memory -> each instruction is preceded by 2 cycles of inst_if=0 with fetch_wait=1; imem_addr is stable during the wait.
- load_stop high for 3 cycles on a word at pc=8 -> pc_if=8 and inst_if equal to that word for 3 cycles, imem_req=0; pc=12 is fetched after release.
- is_branch with target 32'h100 while a request to pc=0x10 is outstanding -> the 0x10 data is discarded on ack; the next imem_addr is 0x100; no 0x14 fetch occurs.
- load_stop and is_branch asserted together in S_HOLD -> PC holds and the branch is ignored; is_branch alone next cycle -> pc becomes the target.
- rst_n pulsed low while in S_DROP -> imem_req=0 immediately, pc=RESET_PC; fetching restarts at RESET_PC after release.
